// File: rtl/decryption_sequencer.sv
// Sequences the byte-wise decryption core over one null-terminated message:
// key check, ciphertext fetch, one-cycle core execution, plaintext hand-off.
module decryption_sequencer #(
    parameter int MAX_LEN = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_load,
    input  logic [7:0] key_in,
    input  logic       start,
    input  logic       abort,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    input  logic       out_ready,
    output logic [1:0] core_mode,
    output logic [7:0] core_ciphertext,
    output logic [7:0] core_secret_key,
    input  logic [7:0] core_plaintext,
    input  logic       core_output_ready,
    input  logic       core_err_seckey,
    input  logic       core_err_ctxt,
    output logic       busy,
    output logic       done,
    output logic       err_key,
    output logic       err_char,
    output logic       err_len,
    output logic [7:0] char_count,
    output logic [7:0] err_index
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FETCH = 3'd1;
    localparam logic [2:0] EXEC  = 3'd2;
    localparam logic [2:0] CAPT  = 3'd3;
    localparam logic [2:0] OUT   = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;
    localparam logic [2:0] ERROR = 3'd6;

    localparam logic [7:0] LEN_LIMIT = 8'(MAX_LEN);

    logic [2:0] state;
    logic [2:0] state_next;
    logic [7:0] key_reg;
    logic [7:0] ct_reg;
    logic [7:0] out_reg;
    logic [7:0] count;
    logic [7:0] index;
    logic       key_flag;
    logic       char_flag;
    logic       len_flag;

    logic accepting;
    logic key_we;
    logic start_ok;
    logic start_bad;
    logic fetch_end;
    logic fetch_byte;
    logic len_hit;
    logic ctxt_bad;
    logic capt_ok;
    logic capt_bad;
    logic out_fire;

    // Abort masks every event so that nothing but the return to IDLE happens.
    always_comb begin
        accepting  = (state == IDLE) || (state == DONE) || (state == ERROR);
        key_we     = !abort && key_load && ((state == IDLE) || (state == ERROR));
        start_bad  = !abort && accepting && start && core_err_seckey;
        start_ok   = !abort && accepting && start && !core_err_seckey;
        fetch_end  = !abort && (state == FETCH) && in_valid && (in_data == 8'h00);
        len_hit    = !abort && (state == FETCH) && in_valid && (in_data != 8'h00)
                     && (count == LEN_LIMIT);
        fetch_byte = !abort && (state == FETCH) && in_valid && (in_data != 8'h00)
                     && (count != LEN_LIMIT);
        ctxt_bad   = !abort && (state == EXEC) && core_err_ctxt;
        capt_ok    = !abort && (state == CAPT) && core_output_ready;
        capt_bad   = !abort && (state == CAPT) && !core_output_ready;
        out_fire   = !abort && (state == OUT) && out_ready;
    end

    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE, DONE, ERROR: begin
                    if (start_bad) begin
                        state_next = ERROR;
                    end else if (start_ok) begin
                        state_next = FETCH;
                    end else if (state == DONE) begin
                        state_next = IDLE;
                    end
                end
                FETCH: begin
                    if (fetch_end) begin
                        state_next = DONE;
                    end else if (len_hit) begin
                        state_next = ERROR;
                    end else if (fetch_byte) begin
                        state_next = EXEC;
                    end
                end
                EXEC:    state_next = ctxt_bad ? ERROR : CAPT;
                CAPT:    state_next = capt_ok ? OUT : ERROR;
                OUT:     state_next = out_fire ? FETCH : OUT;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A start issued together with key_load is judged on the key already held.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_reg <= 8'h00;
        end else if (key_we) begin
            key_reg <= key_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ct_reg <= 8'h00;
        end else if (fetch_byte) begin
            ct_reg <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_reg <= 8'h00;
        end else if (capt_ok) begin
            out_reg <= core_plaintext;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 8'h00;
        end else if (start_ok) begin
            count <= 8'h00;
        end else if (out_fire) begin
            count <= count + 8'd1;
        end
    end

    // Error flags are sticky until a start with a valid key clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            key_flag  <= 1'b0;
            char_flag <= 1'b0;
            len_flag  <= 1'b0;
            index     <= 8'h00;
        end else if (start_ok) begin
            key_flag  <= 1'b0;
            char_flag <= 1'b0;
            len_flag  <= 1'b0;
            index     <= 8'h00;
        end else begin
            if (start_bad) begin
                key_flag <= 1'b1;
            end
            if (ctxt_bad || capt_bad) begin
                char_flag <= 1'b1;
            end
            if (len_hit) begin
                len_flag <= 1'b1;
            end
            if (ctxt_bad || capt_bad || len_hit) begin
                index <= count;
            end
        end
    end

    assign in_ready        = (state == FETCH);
    assign out_valid       = (state == OUT);
    assign out_data        = out_reg;
    assign core_mode       = (state == EXEC) ? 2'b11 : 2'b00;
    assign core_ciphertext = ct_reg;
    assign core_secret_key = key_reg;
    assign busy            = (state == FETCH) || (state == EXEC) ||
                             (state == CAPT) || (state == OUT);
    assign done            = (state == DONE);
    assign err_key         = key_flag;
    assign err_char        = char_flag;
    assign err_len         = len_flag;
    assign char_count      = count;
    assign err_index       = index;

endmodule

// File: tb/tb_decryption_sequencer.sv
// Bench for decryption_sequencer: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_decryption_sequencer;

    localparam int MAXL = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key_load = 1'b0;
    logic [7:0] key_in = 8'h00;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready = 1'b0;
    logic [1:0] core_mode;
    logic [7:0] core_ciphertext;
    logic [7:0] core_secret_key;
    logic [7:0] core_plaintext = 8'h00;
    logic       core_output_ready = 1'b0;
    logic       core_err_seckey;
    logic       core_err_ctxt;
    logic       busy;
    logic       done;
    logic       err_key;
    logic       err_char;
    logic       err_len;
    logic [7:0] char_count;
    logic [7:0] err_index;

    logic       drop_ready = 1'b0;
    logic       xform_en = 1'b0;
    logic       valid_gate = 1'b1;
    logic       chk_en = 1'b0;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] src_q[$];
    logic [7:0] dut_outs[$];

    decryption_sequencer #(.MAX_LEN(MAXL)) dut (
        .clk(clk), .rst(rst), .key_load(key_load), .key_in(key_in),
        .start(start), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .core_mode(core_mode), .core_ciphertext(core_ciphertext),
        .core_secret_key(core_secret_key), .core_plaintext(core_plaintext),
        .core_output_ready(core_output_ready), .core_err_seckey(core_err_seckey),
        .core_err_ctxt(core_err_ctxt), .busy(busy), .done(done),
        .err_key(err_key), .err_char(err_char), .err_len(err_len),
        .char_count(char_count), .err_index(err_index)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] core_xform(input logic [7:0] c, input logic en);
        return en ? {c[3:0], c[7:4]} : c;
    endfunction

    function automatic logic lower_case(input logic [7:0] c);
        return (c >= 8'h61) && (c <= 8'h7A);
    endfunction

    // Stand-in decryption core: one-cycle registered result, combinational flags.
    always @(posedge clk) begin
        if (core_mode == 2'b11) begin
            core_plaintext <= core_xform(core_ciphertext, xform_en);
        end
        core_output_ready <= (core_mode == 2'b11) && !drop_ready;
    end
    assign core_err_seckey = (core_secret_key == 8'd0) || (core_secret_key > 8'd226);
    assign core_err_ctxt   = (core_mode == 2'b11) && !lower_case(core_ciphertext);

    typedef enum logic [2:0] {PH_IDLE, PH_FETCH, PH_EXEC, PH_CAPT, PH_OUT, PH_DONE, PH_ERROR} phase_t;
    phase_t     m_phase = PH_IDLE;
    logic [7:0] m_key = 8'h00, m_ct = 8'h00, m_out = 8'h00, m_cnt = 8'h00, m_idx = 8'h00;
    logic       m_ekey = 1'b0, m_echar = 1'b0, m_elen = 1'b0;
    logic [7:0] m_core_pt = 8'h00;
    logic       m_core_rdy = 1'b0;

    // Reference model: message phases from the operating rules, with its own core.
    always @(posedge clk) begin : ref_model
        logic       was_exec;
        logic       key_bad;
        logic [7:0] ct_old;
        was_exec = (m_phase == PH_EXEC);
        key_bad  = (m_key == 8'd0) || (m_key > 8'd226);
        ct_old   = m_ct;
        if (rst) begin
            m_phase = PH_IDLE; m_key = 8'h00; m_ct = 8'h00; m_out = 8'h00;
            m_cnt = 8'h00; m_idx = 8'h00; m_ekey = 1'b0; m_echar = 1'b0; m_elen = 1'b0;
        end else if (abort) begin
            m_phase = PH_IDLE;
        end else begin
            case (m_phase)
                PH_IDLE, PH_DONE, PH_ERROR: begin
                    if (key_load && m_phase != PH_DONE) m_key = key_in;
                    if (start && key_bad) begin
                        m_ekey = 1'b1;
                        m_phase = PH_ERROR;
                    end else if (start) begin
                        m_cnt = 8'h00; m_idx = 8'h00;
                        m_ekey = 1'b0; m_echar = 1'b0; m_elen = 1'b0;
                        m_phase = PH_FETCH;
                    end else if (m_phase == PH_DONE) begin
                        m_phase = PH_IDLE;
                    end
                end
                PH_FETCH: begin
                    if (in_valid && in_data == 8'h00) begin
                        m_phase = PH_DONE;
                    end else if (in_valid && int'(m_cnt) == MAXL) begin
                        m_elen = 1'b1; m_idx = m_cnt; m_phase = PH_ERROR;
                    end else if (in_valid) begin
                        m_ct = in_data; m_phase = PH_EXEC;
                    end
                end
                PH_EXEC: begin
                    if (!lower_case(m_ct)) begin
                        m_echar = 1'b1; m_idx = m_cnt; m_phase = PH_ERROR;
                    end else begin
                        m_phase = PH_CAPT;
                    end
                end
                PH_CAPT: begin
                    if (m_core_rdy) begin
                        m_out = m_core_pt; m_phase = PH_OUT;
                    end else begin
                        m_echar = 1'b1; m_idx = m_cnt; m_phase = PH_ERROR;
                    end
                end
                PH_OUT: begin
                    if (out_ready) begin
                        m_cnt = m_cnt + 8'd1; m_phase = PH_FETCH;
                    end
                end
                default: m_phase = PH_IDLE;
            endcase
        end
        if (was_exec) m_core_pt = core_xform(ct_old, xform_en);
        m_core_rdy = was_exec && !drop_ready;
    end

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic reportTimeout(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: timeout waiting for condition at %0t", name, $time);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("in_ready", 8'(in_ready), 8'(m_phase == PH_FETCH));
            checkOutput("out_valid", 8'(out_valid), 8'(m_phase == PH_OUT));
            checkOutput("out_data", out_data, m_out);
            checkOutput("core_mode", 8'(core_mode), (m_phase == PH_EXEC) ? 8'd3 : 8'd0);
            checkOutput("core_ciphertext", core_ciphertext, m_ct);
            checkOutput("core_secret_key", core_secret_key, m_key);
            checkOutput("busy", 8'(busy), 8'(m_phase == PH_FETCH || m_phase == PH_EXEC ||
                                               m_phase == PH_CAPT || m_phase == PH_OUT));
            checkOutput("done", 8'(done), 8'(m_phase == PH_DONE));
            checkOutput("err_key", 8'(err_key), 8'(m_ekey));
            checkOutput("err_char", 8'(err_char), 8'(m_echar));
            checkOutput("err_len", 8'(err_len), 8'(m_elen));
            checkOutput("char_count", char_count, m_cnt);
            checkOutput("err_index", err_index, m_idx);
        end
        if (out_valid === 1'b1 && out_ready === 1'b1) dut_outs.push_back(out_data);
    end

    function automatic logic [7:0] outAt(input int i);
        if (i < dut_outs.size()) return dut_outs[i];
        return 8'hxx;
    endfunction

    task automatic refresh();
        in_valid = (src_q.size() != 0) && valid_gate;
        in_data  = in_valid ? src_q[0] : 8'h00;
    endtask

    task automatic tick();
        logic fire;
        @(negedge clk);
        fire = in_valid && in_ready;
        @(posedge clk);
        #1;
        if (fire && src_q.size() != 0) void'(src_q.pop_front());
        refresh();
    endtask

    task automatic applyStimulus(input logic r, input logic kl, input logic [7:0] k,
                                 input logic s, input logic a);
        rst = r; key_load = kl; key_in = k; start = s; abort = a;
        tick();
        rst = 1'b0; key_load = 1'b0; start = 1'b0; abort = 1'b0;
    endtask

    // sel: 0 done, 1 err_char, 2 out_valid, 3 err_len, 4 core_mode EXEC
    task automatic waitUntil(input int sel, input string name);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 60 && !hit; i++) begin
            tick();
            case (sel)
                0:       hit = (done === 1'b1);
                1:       hit = (err_char === 1'b1);
                2:       hit = (out_valid === 1'b1);
                3:       hit = (err_len === 1'b1);
                default: hit = (core_mode === 2'b11);
            endcase
        end
        if (!hit) reportTimeout(name);
    endtask

    function automatic logic [7:0] pickKey();
        case ($urandom_range(0, 5))
            0:       return 8'd0;
            1:       return 8'd227;
            2:       return 8'd226;
            3:       return 8'd1;
            default: return 8'($urandom_range(1, 226));
        endcase
    endfunction

    initial begin
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        chk_en = 1'b1;
        checkOutput("reset_out_valid", 8'(out_valid), 8'h00);
        checkOutput("reset_key", core_secret_key, 8'h00);
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

        // Clean message
        out_ready = 1'b1;
        dut_outs.delete();
        applyStimulus(1'b0, 1'b1, 8'd2, 1'b0, 1'b0);
        src_q = {8'h61, 8'h7A, 8'h00};
        refresh();
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        waitUntil(0, "clean_done");
        checkOutput("clean_count", char_count, 8'd2);
        checkOutput("clean_flags", {5'd0, err_key, err_char, err_len}, 8'h00);
        checkOutput("clean_nouts", 8'(dut_outs.size()), 8'd2);
        checkOutput("clean_out0", outAt(0), 8'h61);
        checkOutput("clean_out1", outAt(1), 8'h7A);
        tick();

        // Bad key 0, then clear with a good message, then bad key 227
        applyStimulus(1'b0, 1'b1, 8'd0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("badkey0_err", 8'(err_key), 8'd1);
        for (int i = 0; i < 3; i++) begin
            checkOutput("badkey0_in_ready", 8'(in_ready), 8'd0);
            checkOutput("badkey0_mode", 8'(core_mode), 8'd0);
            tick();
        end
        applyStimulus(1'b0, 1'b1, 8'd2, 1'b0, 1'b0);
        src_q = {8'h00};
        refresh();
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        waitUntil(0, "badkey_clear_done");
        checkOutput("badkey_cleared", 8'(err_key), 8'd0);
        tick();
        applyStimulus(1'b0, 1'b1, 8'd227, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        checkOutput("badkey227_err", 8'(err_key), 8'd1);
        checkOutput("badkey227_in_ready", 8'(in_ready), 8'd0);

        // Bad character
        applyStimulus(1'b0, 1'b1, 8'd2, 1'b0, 1'b0);
        dut_outs.delete();
        src_q = {8'h41};
        refresh();
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        waitUntil(1, "badchar_flag");
        checkOutput("badchar_err", 8'(err_char), 8'd1);
        checkOutput("badchar_index", err_index, 8'd0);
        checkOutput("badchar_nouts", 8'(dut_outs.size()), 8'd0);

        // Backpressure
        dut_outs.delete();
        out_ready = 1'b0;
        src_q = {8'h62, 8'h00};
        refresh();
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        waitUntil(2, "bp_valid");
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_out_valid", 8'(out_valid), 8'd1);
            checkOutput("bp_out_data", out_data, 8'h62);
            checkOutput("bp_in_ready", 8'(in_ready), 8'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        checkOutput("bp_count", char_count, 8'd1);
        waitUntil(0, "bp_done");
        checkOutput("bp_out0", outAt(0), 8'h62);
        tick();

        // Length limit (MAXL = 3)
        dut_outs.delete();
        src_q = {8'h61, 8'h62, 8'h63, 8'h64, 8'h00};
        refresh();
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        waitUntil(3, "len_flag");
        checkOutput("len_nouts", 8'(dut_outs.size()), 8'd3);
        checkOutput("len_out2", outAt(2), 8'h63);
        checkOutput("len_err", 8'(err_len), 8'd1);
        checkOutput("len_index", err_index, 8'd3);
        src_q.delete();
        refresh();

        // Abort in EXEC
        dut_outs.delete();
        src_q = {8'h61, 8'h00};
        refresh();
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        waitUntil(4, "abort_exec");
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        checkOutput("abort_mode", 8'(core_mode), 8'd0);
        checkOutput("abort_busy", 8'(busy), 8'd0);
        src_q.delete();
        refresh();
        for (int i = 0; i < 3; i++) tick();
        checkOutput("abort_nouts", 8'(dut_outs.size()), 8'd0);

        // Reset during OUT
        out_ready = 1'b0;
        src_q = {8'h61, 8'h00};
        refresh();
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        waitUntil(2, "rst_out_valid");
        applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("rst_out_valid", 8'(out_valid), 8'd0);
        checkOutput("rst_out_data", out_data, 8'h00);
        checkOutput("rst_key", core_secret_key, 8'h00);
        checkOutput("rst_busy", 8'(busy), 8'd0);
        src_q.delete();
        refresh();

        // Randomized traffic
        xform_en = 1'b1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            out_ready  = ($urandom_range(0, 9) < 7);
            drop_ready = ($urandom_range(0, 29) == 0);
            valid_gate = ($urandom_range(0, 9) < 8);
            if (src_q.size() == 0) begin
                int len;
                len = $urandom_range(0, 5);
                for (int j = 0; j < len; j++) begin
                    if ($urandom_range(0, 7) == 0) src_q.push_back(8'($urandom_range(8'h41, 8'h5A)));
                    else                           src_q.push_back(8'($urandom_range(8'h61, 8'h7A)));
                end
                src_q.push_back(8'h00);
            end
            refresh();
            applyStimulus($urandom_range(0, 399) == 0, $urandom_range(0, 9) == 0, pickKey(),
                          $urandom_range(0, 5) == 0, $urandom_range(0, 79) == 0);
        end

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decryption_sequencer.md
# decryption_sequencer

Controller that sequences the byte-wise decryption core over a whole message. It loads and validates the secret key, fetches ciphertext bytes from an upstream valid/ready stream, and issues each byte to the core with mode 2'b11. It then captures the core's registered plaintext and forwards it downstream with backpressure, stopping on the null terminator or on the first error. It sits between the input byte buffer and the decryption core.

## Interface
- MAX_LEN, 64, maximum characters per message (1..255)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- key_load  in  1  capture key_in into key register (IDLE only)
- key_in  in  8  secret key value
- start  in  1  begin a message (IDLE/DONE/ERROR only)
- abort  in  1  return to IDLE from any state
- in_valid / in_data[7:0] / in_ready  in/in/out  1/8/1  ciphertext stream; 8'h00 = end of message
- out_valid / out_data[7:0] / out_ready  out/out/in  1/8/1  plaintext stream
- core_mode  out  2  2'b11 in EXEC only, else 2'b00
- core_ciphertext  out  8  registered byte under decryption
- core_secret_key  out  8  key register
- core_plaintext  in  8  core registered result
- core_output_ready  in  1  core registered valid
- core_err_seckey  in  1  core combinational key-range flag (key outside 1..226)
- core_err_ctxt  in  1  core combinational flag, valid only while core_mode=2'b11
- busy  out  1  high in FETCH/EXEC/CAPT/OUT
- done  out  1  one-cycle pulse on clean end of message
- err_key, err_char, err_len  out  1  sticky error flags
- char_count  out  8  characters delivered downstream in current message
- err_index  out  8  char_count value when err_char/err_len set

## Operation
- States: IDLE, FETCH, EXEC, CAPT, OUT, DONE, ERROR.
- IDLE: key_load writes key register. start: if core_err_seckey=1, go to ERROR with err_key set; else clear char_count and all error flags, go to FETCH.
- FETCH: in_ready=1.
  - in_valid with in_data=8'h00: go to DONE.
  - in_valid with nonzero in_data and char_count=MAX_LEN: go to ERROR with err_len set.
  - Other in_valid with nonzero in_data: load core_ciphertext, go to EXEC.
- EXEC: core_mode=2'b11 for exactly one cycle.
  - core_err_ctxt=1: go to ERROR with err_char set and err_index=char_count.
  - Otherwise go to CAPT.
- CAPT: requires core_output_ready=1.
  - If so, latch core_plaintext into out_data and go to OUT.
  - If not, go to ERROR with err_char set (defensive).
- OUT: out_valid=1 with out_data stable until out_ready. On handshake, char_count+1 and go to FETCH.
- DONE: done=1 for one cycle, then IDLE. char_count holds.
- ERROR: busy=0. Flags and err_index hold until the next accepted start or reset. start behaves as in IDLE. key_load is accepted.
- abort (priority over all transitions): next state IDLE. out_valid and core_mode drop the next cycle. Flags and char_count hold.
- key_load and start are ignored while busy. key_load and start in the same IDLE cycle: start uses the old key; the new key is stored.
- Reset values: state IDLE, key register 8'h00, all outputs 0 (out_data 8'h00, core_mode 2'b00).

## Timing
- Per character: FETCH, EXEC, CAPT, OUT = minimum 4 cycles, assuming in_valid and out_ready both high.
- First out_valid appears 3 cycles after the FETCH handshake cycle.
- The core's registered output is sampled in the cycle after EXEC.
- in_ready is high only in FETCH. It is never high while out_valid=1.
- done asserts the cycle after the terminator handshake.
- Error flags assert the cycle after the detecting state.
- rst mid-message: next cycle all outputs are at reset values. Any pending out byte is lost and the upstream byte is not re-requested.

## Test plan
- Clean message: key=2, stream 8'h61, 8'h7A, 8'h00, out_ready=1 -> out 8'h61 then 8'h7A. done pulse one cycle after the terminator handshake; char_count=2; no flags.
- Bad key: key=0 (repeat with key=227), start -> err_key=1 the next cycle. in_ready never asserts; core_mode stays 2'b00.
- Bad char: key=2, stream 8'h41 -> core gives 8'h41 (not lowercase) -> err_char=1, err_index=0. out_valid never asserts.
- Backpressure: key=2, byte 8'h62, out_ready low 5 cycles -> out_valid=1 and out_data=8'h62 stable throughout, in_ready=0. The byte is accepted on the cycle out_ready rises; char_count becomes 1.
- Length limit: MAX_LEN=2, stream 8'h61, 8'h62, 8'h63 -> two outputs, then err_len=1 with err_index=2.
- Abort and reset: abort asserted in EXEC -> IDLE next cycle, core_mode=2'b00, no output. rst asserted during OUT -> all outputs return to reset values the next cycle.
